// File: rtl/pdm_pcm_decimator_mc.sv
// rtl/pdm_pcm_decimator_mc.sv - multi-channel PDM to PCM box-car decimator with channel-tagged FIFO output
//
// Purpose: counts ones per PDM lane over a frame of R beats. R is clamped to
// 2..MAX_DECIMATION and latched, together with the gain shift, on the first
// beat of each frame. It then forms (2N-R) << shift, saturates that value to
// signed DATA_WIDTH, and serialises the channels into one shared
// first-word-fall-through FIFO.
//
// Ports:
//   clock_i, reset_i        clock, synchronous active-high reset
//   enable_i                block enable; dropping it discards a partial frame
//   decim_ratio_i           decimation ratio R (clamped)
//   gain_shift_i            left shift applied to 2N-R
//   pdm_data_i/valid_i      one PDM bit per channel per beat
//   pdm_ready_o             mirrors enable_i
//   pcm_data_o/channel_o    FIFO head sample and its channel tag
//   pcm_valid_o/ready_i     FIFO pop handshake
//   busy_o                  partial frame held or serialiser running
//   fifo_level_o            FIFO occupancy
//   overflow_o/underflow_o  sticky drop / discard flags
//   status_clear_i          clears both sticky flags
module pdm_pcm_decimator_mc #(
  parameter int NUM_CHANNELS   = 2,
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_DECIMATION = 48,
  parameter int FIFO_DEPTH     = 16,
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic [5:0]              decim_ratio_i,
  input  logic [4:0]              gain_shift_i,
  input  logic [NUM_CHANNELS-1:0] pdm_data_i,
  input  logic                    pdm_valid_i,
  output logic                    pdm_ready_o,
  output logic [DATA_WIDTH-1:0]   pcm_data_o,
  output logic [CW-1:0]           pcm_channel_o,
  output logic                    pcm_valid_o,
  input  logic                    pcm_ready_i,
  output logic                    busy_o,
  output logic [LW-1:0]           fifo_level_o,
  output logic                    overflow_o,
  output logic                    underflow_o,
  input  logic                    status_clear_i
);

  localparam logic [5:0]       RMAX    = 6'(MAX_DECIMATION);
  localparam logic [CW-1:0]    LAST_CH = CW'(NUM_CHANNELS - 1);
  localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (DATA_WIDTH - 1));

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, SERIAL = 2'd2} state_t;

  // 64-bit intermediate: |2N-R| <= 48 shifted by up to 31 cannot overflow
  function automatic logic [DATA_WIDTH-1:0] scale_sat(input logic [5:0] n,
                                                      input logic [5:0] r,
                                                      input logic [4:0] sh);
    logic signed [63:0] v;
    logic signed [63:0] s;
    v = $signed({57'd0, n, 1'b0}) - $signed({58'd0, r});
    s = v <<< sh;
    if (s > SAT_MAX)      s = SAT_MAX;
    else if (s < SAT_MIN) s = SAT_MIN;
    return s[DATA_WIDTH-1:0];
  endfunction

  state_t                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [5:0]            r_q, r_d;
  logic [4:0]            shift_q, shift_d;
  logic [5:0]            n_q    [NUM_CHANNELS];
  logic [5:0]            n_d    [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] hold_q [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] hold_d [NUM_CHANNELS];
  logic [CW-1:0]         ser_idx_q, ser_idx_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;

  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [CW-1:0]         fifo_chan_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q;

  logic       beat, first_beat, frame_done, frame_drop, frame_load, discard;
  logic       serial, last_write, push, pop, full, push_ok, push_drop;
  logic [5:0] ratio_clamped, cur_r;

  always_comb begin
    ratio_clamped = decim_ratio_i;
    if (decim_ratio_i < 6'd2)    ratio_clamped = 6'd2;
    else if (decim_ratio_i > RMAX) ratio_clamped = RMAX;
  end

  assign beat       = pdm_valid_i && enable_i;
  assign first_beat = (cnt_q == 6'd0);
  // the ratio in force on the first beat is the live (clamped) input
  assign cur_r      = first_beat ? ratio_clamped : r_q;
  assign frame_done = beat && (cnt_q == cur_r - 6'd1);
  assign serial     = (state_q == SERIAL);
  assign last_write = serial && (ser_idx_q == LAST_CH);
  // the holding register is free only on the edge of its final write
  assign frame_drop = frame_done && serial && !last_write;
  assign frame_load = frame_done && !frame_drop;
  assign discard    = !enable_i && (cnt_q != 6'd0);

  assign push      = serial;
  assign pop       = pcm_valid_o && pcm_ready_i;
  assign full      = (level_q == LW'(FIFO_DEPTH));
  assign push_ok   = push && (!full || pop);
  assign push_drop = push && !push_ok;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    shift_d   = shift_q;
    ser_idx_d = ser_idx_q;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      n_d[c]    = n_q[c];
      hold_d[c] = hold_q[c];
    end

    if (beat) begin
      if (first_beat) begin
        r_d     = ratio_clamped;
        shift_d = gain_shift_i;
      end
      cnt_d = frame_done ? 6'd0 : cnt_q + 6'd1;
      for (int c = 0; c < NUM_CHANNELS; c++)
        n_d[c] = frame_done ? 6'd0 : n_q[c] + 6'(pdm_data_i[c]);
    end else if (discard) begin
      cnt_d = 6'd0;
      for (int c = 0; c < NUM_CHANNELS; c++) n_d[c] = 6'd0;
    end

    // a completing frame never starts on its first beat, so r_q/shift_q hold it
    if (frame_load)
      for (int c = 0; c < NUM_CHANNELS; c++)
        hold_d[c] = scale_sat(n_q[c] + 6'(pdm_data_i[c]), r_q, shift_q);

    case (state_q)
      IDLE:   if (enable_i) state_d = ACCUM;
      ACCUM:  if (!enable_i) state_d = IDLE;
      SERIAL: begin
        if (last_write) begin
          ser_idx_d = '0;
          state_d   = enable_i ? ACCUM : IDLE;
        end else begin
          ser_idx_d = ser_idx_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (frame_load) begin
      state_d   = SERIAL;
      ser_idx_d = '0;
    end

    ovf_d = status_clear_i ? 1'b0 : ovf_q;
    if (frame_drop || push_drop) ovf_d = 1'b1;
    unf_d = status_clear_i ? 1'b0 : unf_q;
    if (discard) unf_d = 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      r_q       <= '0;
      shift_q   <= '0;
      ser_idx_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        n_q[c]    <= '0;
        hold_q[c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      shift_q   <= shift_d;
      ser_idx_q <= ser_idx_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q   <= level_q + LW'(push_ok) - LW'(pop);
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        n_q[c]    <= n_d[c];
        hold_q[c] <= hold_d[c];
      end
    end
  end

  // storage is not reset; its contents are only visible while valid
  always_ff @(posedge clock_i) begin
    if (push_ok) begin
      fifo_data_q[wr_ptr_q] <= hold_q[ser_idx_q];
      fifo_chan_q[wr_ptr_q] <= ser_idx_q;
    end
  end

  assign pdm_ready_o   = enable_i;
  assign pcm_valid_o   = (level_q != '0);
  assign pcm_data_o    = pcm_valid_o ? fifo_data_q[rd_ptr_q] : '0;
  assign pcm_channel_o = pcm_valid_o ? fifo_chan_q[rd_ptr_q] : '0;
  assign busy_o        = (cnt_q != 6'd0) || serial;
  assign fifo_level_o  = level_q;
  assign overflow_o    = ovf_q;
  assign underflow_o   = unf_q;

endmodule

// File: doc/pdm_pcm_decimator_mc.md
Name: pdm_pcm_decimator_mc

Overview:
Multi-channel, runtime-configurable successor to the single-channel PDM-to-PCM decimator. It accepts NUM_CHANNELS PDM bits per valid beat and box-car decimates each channel over a programmable ratio of 2..48. Each channel result is scaled and saturated to signed DATA_WIDTH PCM. Results are serialised into one shared FWFT FIFO as a channel-tagged valid/ready stream feeding the audio back end.

Parameters:
NUM_CHANNELS, 2, number of PDM lanes (1..8)
DATA_WIDTH, 16, PCM sample width, signed (8..32)
MAX_DECIMATION, 48, upper clamp for decim_ratio_i
FIFO_DEPTH, 16, output FIFO entries (power of 2, >=2)

Ports:
clock_i  in  1  single clock
reset_i  in  1  synchronous, active-high reset
enable_i  in  1  block enable
decim_ratio_i  in  6  decimation ratio R; clamped to [2, MAX_DECIMATION]
gain_shift_i  in  5  left shift applied to the raw result
pdm_data_i  in  NUM_CHANNELS  one PDM bit per channel
pdm_valid_i  in  1  PDM beat valid
pdm_ready_o  out  1  equals enable_i; no other backpressure
pcm_data_o  out  DATA_WIDTH  signed PCM sample at FIFO head
pcm_channel_o  out  max(1,$clog2(NUM_CHANNELS))  channel index of the head sample
pcm_valid_o  out  1  FIFO not empty
pcm_ready_i  in  1  consumer pops when pcm_valid_o && pcm_ready_i
busy_o  out  1  frame partially accumulated or serialiser active
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow_o  out  1  sticky: a sample or frame was dropped
underflow_o  out  1  sticky: a partial frame was discarded by disable
status_clear_i  in  1  clears both sticky flags

Behaviour:
- Reset (reset_i=1 at clock edge): all outputs 0, FIFO empty, counters and accumulators 0, FSM in IDLE. Reset wins over every other event and applies mid-frame.
- Beat accepted when pdm_valid_i && enable_i. Per channel, N increments on a 1 bit; a shared bit counter counts beats.
- R and gain_shift_i are latched on the first beat of each frame. Changes mid-frame take effect on the next frame.
- Frame completes on the beat where the counter reaches R-1 (edge E0):
  - per channel v = 2N-R (signed, 7 bits), s = v << shift, saturated to [-2^(DW-1), 2^(DW-1)-1];
  - results load the holding register at E0; counter and N clear at E0.
- FSM states:
  - IDLE: enable_i=0. Goes to ACCUM when enable_i=1.
  - ACCUM: accumulating. Goes to SERIAL at frame completion.
  - SERIAL: channel k is written to the FIFO at edge E0+1+k, k=0..C-1. Returns to ACCUM after the final write, or to IDLE if disabled. Accumulation continues during SERIAL.
- Holding register may reload on the edge of its final write (R==C is lossless).
  - If a frame completes while an earlier write is still pending (R<C), the whole new frame is dropped and overflow_o is set.
- FIFO write while full, with no simultaneous pop: that sample is dropped, overflow_o=1, other channels unaffected. Push and pop on the same edge while full: push accepted.
- Output visibility: pcm_valid_o rises the cycle after a write into an empty FIFO.
  - Data is stable while valid && !ready.
  - pop on valid && ready; level updates every edge.
- enable_i falling:
  - mid-frame (counter != 0): partial frame discarded, counter and N cleared, underflow_o=1;
  - a pending SERIAL completes first;
  - FIFO contents retained and drainable while disabled.
- status_clear_i clears both sticky flags. A set event on the same edge wins.
- busy_o = (counter != 0) || SERIAL.

Test Plan:
- C=2, DW=16, R=16, shift=8; ch0 all ones, ch1 alternating 0/1 -> FIFO holds (ch0, 4096) then (ch1, 0); first pcm_valid_o two cycles after the last beat's edge.
- R=48, shift=12; ch0 all ones, ch1 all zeros -> ch0=32767, ch1=-32768 (saturated); decim_ratio_i=1 -> frame length 2; decim_ratio_i=60 -> frame length 48.
- pcm_ready_i=0, R=4, C=2, FIFO_DEPTH=16 -> 8 frames fill level 16; the 9th frame's samples are dropped, overflow_o=1, level stays 16; status_clear_i clears the flag.
- C=4, R=2, continuous pdm_valid_i -> every second frame dropped, overflow_o=1, no reordering of channel tags (0,1,2,3 repeating).
- 5 beats, then enable_i=0 -> underflow_o=1, busy_o=0; re-enable -> next full frame correct; R changed mid-frame -> applied to the following frame only.
- reset_i asserted during SERIAL with 3 samples queued -> next edge: pcm_valid_o=0, level 0, flags 0, FSM IDLE.
